// File: rtl/mem_align_unit_pkg.sv
// Shared types and helpers for the load/store alignment unit.
package mem_align_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // Natural alignment check; the illegal size code is always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Byte enables for a store of the given size at the given lane offset.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across every lane it could land in,
  // so the byte enables alone pick the destination.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_align_unit_signext.sv
// Generic sign extender: replicates the MSB of the input up to OUT_WIDTH.
module mem_align_unit_signext #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0]  data_i,
  output logic [OUT_WIDTH-1:0] data_o
);

  assign data_o = {{(OUT_WIDTH - IN_WIDTH){data_i[IN_WIDTH-1]}}, data_i};

endmodule

// File: rtl/mem_align_unit.sv
// Load/store alignment unit: takes byte/half/word CPU requests, drives a
// word-wide synchronous memory with lane enables, and returns extended load
// data or a misalignment flag as a single-cycle response.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | memory strobe cycle
// WAIT   | load data returning; lane extracted and registered
// RESP   | one-cycle response pulse
module mem_align_unit
  import mem_align_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_misaligned,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                  state_q, state_d;
  logic                    we_q, uns_q, mis_q;
  logic [1:0]              size_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   maddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic                    accept;
  logic                    req_mis;
  logic [7:0]              byte_lane;
  logic [15:0]             half_lane;
  logic [DATA_WIDTH-1:0]   byte_sext, half_sext;

  // Ready is also gated by reset so it reads 0 while reset is held.
  assign req_ready = (state_q == IDLE) & ~reset;
  assign accept    = req_valid & req_ready;
  assign req_mis   = is_misaligned(req_size, req_addr[1:0]);
  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  // Outside ACCESS the address holds the last one actually sent to memory.
  assign mem_addr       = (state_q == ACCESS) ? word_addr : maddr_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_misaligned = rsp_valid & mis_q;

  // State register; reset forces IDLE asynchronously so strobes drop at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and memory/response strobes.
  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = req_mis ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        mem_en  = 1'b1;
        mem_we  = we_q;
        if (we_q) begin
          mem_be    = store_be(size_q, addr_q[1:0]);
          mem_wdata = store_data(size_q, wdata_q);
          state_d   = RESP;
        end else begin
          mem_be  = 4'b1111;
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lane selection from the returning memory word.
  always_comb begin
    byte_lane = 8'h00;
    case (addr_q[1:0])
      2'd0: byte_lane = mem_rdata[7:0];
      2'd1: byte_lane = mem_rdata[15:8];
      2'd2: byte_lane = mem_rdata[23:16];
      2'd3: byte_lane = mem_rdata[31:24];
      default: byte_lane = 8'h00;
    endcase
    half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  mem_align_unit_signext #(.IN_WIDTH(8), .OUT_WIDTH(DATA_WIDTH)) u_sext_byte (
    .data_i (byte_lane),
    .data_o (byte_sext)
  );

  mem_align_unit_signext #(.IN_WIDTH(16), .OUT_WIDTH(DATA_WIDTH)) u_sext_half (
    .data_i (half_lane),
    .data_o (half_sext)
  );

  // Choose sign- or zero-extended lane; word loads pass straight through.
  always_comb begin
    load_ext = mem_rdata;
    case (size_q)
      SZ_BYTE: load_ext = uns_q ? {24'h000000, byte_lane} : byte_sext;
      SZ_HALF: load_ext = uns_q ? {16'h0000, half_lane} : half_sext;
      default: load_ext = mem_rdata;
    endcase
  end

  // Request capture, last-accessed address and response data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      maddr_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        mis_q   <= req_mis;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (req_mis) begin
          rdata_q <= '0;
        end
      end
      if (state_q == ACCESS) begin
        maddr_q <= word_addr;
        if (we_q) begin
          rdata_q <= '0;
        end
      end
      if (state_q == WAIT) begin
        rdata_q <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed plus randomized bench for mem_align_unit with an arithmetic
// reference model of lane placement and load extension.
module tb_mem_align_unit;
  import mem_align_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int          n_checks;
  int          n_fail;
  logic [31:0] last_maddr;
  logic [31:0] hold_rdata;
  int          nacc;
  int          nrsp;

  mem_align_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_misaligned (rsp_misaligned),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_be         (mem_be),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_rspv"},  {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_mis"},   {31'd0, rsp_misaligned}, 32'd0);
    chk({tag, "_en"},    {31'd0, mem_en}, 32'd0);
    chk({tag, "_we"},    {31'd0, mem_we}, 32'd0);
    chk({tag, "_be"},    {28'd0, mem_be}, 32'd0);
    chk({tag, "_addr"},  mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  // One complete transaction. Entered and left just after a falling edge
  // with the unit idle. Expected values come from plain arithmetic on the
  // request; the memory word is presented only during the cycle after the
  // strobe, with noise before and after.
  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mrd);
    logic        mis;
    logic        acc;
    int          lat;
    logic [31:0] off, v, exp_be, exp_wd, exp_rd, exp_wa;
    off    = addr & 32'd3;
    exp_wa = addr & ~32'd3;
    mis    = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && off != 0);
    exp_be = 32'hF;
    exp_wd = wd;
    exp_rd = 32'd0;
    if (we) begin
      if (sz == 2'b00) begin
        exp_be = 32'd1 << off;
        exp_wd = (wd & 32'hFF) * 32'h01010101;
      end else if (sz == 2'b01) begin
        exp_be = 32'd3 << (off & 32'd2);
        exp_wd = (wd & 32'hFFFF) * 32'h00010001;
      end
    end else if (!mis) begin
      if (sz == 2'b00) begin
        v = (mrd >> (8 * off)) & 32'hFF;
        if (!uns && v >= 32'd128) v = v - 32'd256;
      end else if (sz == 2'b01) begin
        v = (mrd >> (16 * (off >> 1))) & 32'hFFFF;
        if (!uns && v >= 32'd32768) v = v - 32'd65536;
      end else begin
        v = mrd;
      end
      exp_rd = v;
    end
    lat = mis ? 1 : (we ? 2 : 3);

    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    mem_rdata    = $urandom;
    @(negedge clk);
    for (int k = 1; k <= lat; k++) begin
      acc = (k == 1) && !mis;
      chk("rsp_valid", {31'd0, rsp_valid}, (k == lat) ? 32'd1 : 32'd0);
      chk("busy_ready", {31'd0, req_ready}, 32'd0);
      chk("mem_en", {31'd0, mem_en}, {31'd0, acc});
      if (acc) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, we});
        chk("mem_be", {28'd0, mem_be}, exp_be);
        chk("mem_addr", mem_addr, exp_wa);
        if (we) chk("mem_wdata", mem_wdata, exp_wd);
        last_maddr = exp_wa;
      end else begin
        chk("idle_we", {31'd0, mem_we}, 32'd0);
        chk("idle_be", {28'd0, mem_be}, 32'd0);
        chk("idle_wdata", mem_wdata, 32'd0);
        chk("hold_addr", mem_addr, last_maddr);
      end
      if (k == lat) begin
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_mis", {31'd0, rsp_misaligned}, {31'd0, mis});
      end else begin
        chk("mis_unqual", {31'd0, rsp_misaligned}, 32'd0);
      end
      if (k == 1) begin
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
      end
      mem_rdata = (k == 2) ? mrd : $urandom;
      @(negedge clk);
    end
    hold_rdata = exp_rd;
    chk("post_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("post_mis", {31'd0, rsp_misaligned}, 32'd0);
    chk("post_ready", {31'd0, req_ready}, 32'd1);
    chk("post_hold", rsp_rdata, hold_rdata);
    chk("post_en", {31'd0, mem_en}, 32'd0);
  endtask

  initial begin
    logic [1:0] rsz;
    n_checks     = 0;
    n_fail       = 0;
    last_maddr   = 32'd0;
    hold_rdata   = 32'd0;
    reset        = 1'b1;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = SZ_WORD;
    req_unsigned = 1'b0;
    req_addr     = 32'h0000_1234;
    req_wdata    = 32'hDEAD_BEEF;
    mem_rdata    = 32'hFFFF_FFFF;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);

    // Byte store to the top lane.
    txn(1'b1, SZ_BYTE, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0);
    // Signed and unsigned byte loads from lane 2.
    txn(1'b0, SZ_BYTE, 1'b0, 32'h0000_2002, 32'h0, 32'h1280_7F34);
    txn(1'b0, SZ_BYTE, 1'b1, 32'h0000_2002, 32'h0, 32'h1280_7F34);
    // Signed and unsigned halfword loads from the upper half.
    txn(1'b0, SZ_HALF, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_FFFF);
    txn(1'b0, SZ_HALF, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_FFFF);
    // Misaligned word load, misaligned half store, illegal size.
    txn(1'b0, SZ_WORD, 1'b0, 32'h0000_3002, 32'h0, 32'h5555_AAAA);
    txn(1'b1, SZ_HALF, 1'b0, 32'h0000_3001, 32'h0000_BEEF, 32'h0);
    txn(1'b0, SZ_ILLEGAL, 1'b1, 32'h0000_3000, 32'h0, 32'h1234_5678);
    // Aligned word load and half store around the misaligned ones.
    txn(1'b0, SZ_WORD, 1'b0, 32'h0000_3004, 32'h0, 32'hCAFE_F00D);
    txn(1'b1, SZ_HALF, 1'b0, 32'h0000_3002, 32'h1234_BEEF, 32'h0);

    // Reset during WAIT of a load.
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = SZ_BYTE;
    req_unsigned = 1'b0;
    req_addr     = 32'h0000_4001;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rw_access_en", {31'd0, mem_en}, 32'd1);
    @(negedge clk);
    chk("rw_wait_en", {31'd0, mem_en}, 32'd0);
    reset = 1'b1;
    #1;
    chk_all_zero("rw_in_reset");
    @(negedge clk);
    chk("rw_rspv", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rw_rspv2", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rw_ready", {31'd0, req_ready}, 32'd1);
    last_maddr = 32'd0;
    hold_rdata = 32'd0;
    @(negedge clk);
    chk("rw_no_rsp", {31'd0, rsp_valid}, 32'd0);
    txn(1'b1, SZ_WORD, 1'b0, 32'h0000_0000, 32'h0BAD_F00D, 32'h0);

    // Reset during ACCESS must drop the strobe in the same cycle.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = SZ_WORD;
    req_addr  = 32'h0000_6000;
    req_wdata = 32'h1111_2222;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ra_en", {31'd0, mem_en}, 32'd1);
    reset = 1'b1;
    #1;
    chk("ra_en_drop", {31'd0, mem_en}, 32'd0);
    chk("ra_be_drop", {28'd0, mem_be}, 32'd0);
    @(negedge clk);
    chk("ra_rspv", {31'd0, rsp_valid}, 32'd0);
    reset      = 1'b0;
    last_maddr = 32'd0;
    hold_rdata = 32'd0;
    @(negedge clk);

    // Back-to-back word stores with req_valid held high.
    nacc      = 0;
    nrsp      = 0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = SZ_WORD;
    req_addr  = 32'h0000_5000;
    req_wdata = 32'h7777_8888;
    for (int i = 0; i < 12; i++) begin
      chk("b2b_ready", {31'd0, req_ready}, (i % 3 == 0) ? 32'd1 : 32'd0);
      if (req_ready) nacc++;
      if (rsp_valid) nrsp++;
      if (i == 11) req_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_accepts", nacc, 32'd4);
    chk("b2b_rsps", nrsp, 32'd4);
    last_maddr = 32'h0000_5000;
    hold_rdata = 32'd0;

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      rsz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      txn(1'($urandom), rsz, 1'($urandom), $urandom, $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
